mrx_sync_det: RTL and testbench

// Receive-side sync detector and capture gate for the multi-tone link: watches the TX sync line on the GPIO input bus,

---
 rtl/mrx_sync_det_if.sv | 38 +++
 rtl/mrx_sync_det.sv | 242 ++++++++++++++++++++++++
 tb/tb_mrx_sync_det.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mrx_sync_det_if.sv
`default_nettype none
// ============================================================================
//  Module   : mrx_sync_det_if
//  Brief    : Bundle of GPIO, RX IQ and capture-status signals around the
//             multi-tone RX sync detector. The slave modport is the detector
//             side; the master modport is the GPIO/IQ source and status sink.
//  Revision : 1.0  initial release
// ============================================================================
interface mrx_sync_det_if #(
    parameter int DATA_WIDTH     = 16,
    parameter int GPIO_REG_WIDTH = 12,
    parameter int CNT_WIDTH      = 24
);
    logic [GPIO_REG_WIDTH-1:0]       gpio_in;
    logic [DATA_WIDTH-1:0]           irx;
    logic [DATA_WIDTH-1:0]           qrx;
    logic [DATA_WIDTH-1:0]           irx_out;
    logic [DATA_WIDTH-1:0]           qrx_out;
    logic                            rx_valid;
    logic                            rx_trig;
    logic                            sync_locked;
    logic                            sync_err;
    logic [CNT_WIDTH-1:0]            pulse_len;
    logic [DATA_WIDTH+CNT_WIDTH-1:0] noise_floor;

    modport slave (
        input  gpio_in, irx, qrx,
        output irx_out, qrx_out, rx_valid, rx_trig,
               sync_locked, sync_err, pulse_len, noise_floor
    );

    modport master (
        output gpio_in, irx, qrx,
        input  irx_out, qrx_out, rx_valid, rx_trig,
               sync_locked, sync_err, pulse_len, noise_floor
    );
endinterface
`default_nettype wire

// File: rtl/mrx_sync_det.sv
`default_nettype none
// ============================================================================
//  Module   : mrx_sync_det
//  Brief    : RX sync detector and capture gate. Synchronises and deglitches
//             the TX sync line, measures the sync pulse, and on an accepted
//             falling edge opens an RX_WIN_LEN-cycle IQ capture window.
//             Optional feature macro: MRX_NOISE_EST_EN (sum of |I|+|Q| over
//             the silent half of the sync pulse, reported on noise_floor).
//  Revision : 1.0  initial release
// ============================================================================
module mrx_sync_det #(
    parameter int DATA_WIDTH     = 16,
    parameter int GPIO_REG_WIDTH = 12,
    parameter int SYNC_BIT       = 1,
    parameter int SYNC_SIG_N     = 8256,
    parameter int SYNC_TOL       = 64,
    parameter int GLITCH_LEN     = 4,
    parameter int CNT_WIDTH      = 24,
    parameter int RX_WIN_LEN     = 8388608
) (
    input wire             clk,
    input wire             reset,
    mrx_sync_det_if.slave  bus
);

    localparam int                   c_FILT_W    = $clog2(GLITCH_LEN) + 1;
    localparam logic [c_FILT_W-1:0]  c_FILT_LAST = c_FILT_W'(GLITCH_LEN - 1);
    localparam logic [CNT_WIDTH:0]   c_PULSE_MIN = (CNT_WIDTH+1)'(2*SYNC_SIG_N - SYNC_TOL);
    localparam logic [CNT_WIDTH:0]   c_PULSE_MAX = (CNT_WIDTH+1)'(2*SYNC_SIG_N + SYNC_TOL);
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX   = '1;
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] c_WIN_LAST  = CNT_WIDTH'(RX_WIN_LEN - 1);
    localparam int                   c_NF_W      = DATA_WIDTH + CNT_WIDTH;

    typedef enum logic [1:0] {
        S_WAIT_LOW = 2'd0,
        S_IDLE     = 2'd1,
        S_HIGH     = 2'd2,
        S_RX       = 2'd3
    } state_t;

    // Only the sync bit matters; the rest of the GPIO bus is intentionally ignored.
    logic w_unused_gpio;
    assign w_unused_gpio = ^bus.gpio_in;

    logic                r_sync_meta;
    logic                r_sync_q;
    logic                r_filt;
    logic                r_filt_d;
    logic [c_FILT_W-1:0] r_filt_cnt;
    logic                w_rise;
    logic                w_fall;

    // Two-flop synchroniser, then accept a new level only after GLITCH_LEN equal samples.
    // Everything resets high so a line that is already high never looks like an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync_meta <= 1'b1;
            r_sync_q    <= 1'b1;
            r_filt      <= 1'b1;
            r_filt_d    <= 1'b1;
            r_filt_cnt  <= '0;
        end else begin
            r_sync_meta <= bus.gpio_in[SYNC_BIT];
            r_sync_q    <= r_sync_meta;
            r_filt_d    <= r_filt;
            if (r_sync_q == r_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == c_FILT_LAST) begin
                r_filt     <= r_sync_q;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    assign w_rise = r_filt & ~r_filt_d;
    assign w_fall = ~r_filt & r_filt_d;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_WIDTH-1:0] r_pulse_cnt;
    logic [CNT_WIDTH-1:0] w_pulse_cnt_nxt;
    logic [CNT_WIDTH-1:0] r_win_cnt;
    logic [CNT_WIDTH-1:0] w_win_cnt_nxt;
    logic                 w_len_ok;
    logic                 w_accept;
    logic                 w_reject;
    logic                 w_trunc;
    logic                 w_in_win;

    assign w_len_ok = ({1'b0, r_pulse_cnt} >= c_PULSE_MIN) &&
                      ({1'b0, r_pulse_cnt} <= c_PULSE_MAX);

    // Next-state, counter updates and per-cycle event strobes.
    always_comb begin
        w_state_nxt     = r_state;
        w_pulse_cnt_nxt = r_pulse_cnt;
        w_win_cnt_nxt   = r_win_cnt;
        w_accept        = 1'b0;
        w_reject        = 1'b0;
        w_trunc         = 1'b0;
        w_in_win        = 1'b0;
        case (r_state)
            S_WAIT_LOW: begin
                if (!r_filt) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (w_rise) begin
                    w_state_nxt     = S_HIGH;
                    w_pulse_cnt_nxt = c_CNT_ONE;
                end
            end
            S_HIGH: begin
                if (w_fall) begin
                    if (w_len_ok) begin
                        w_accept      = 1'b1;
                        w_state_nxt   = S_RX;
                        w_win_cnt_nxt = '0;
                    end else begin
                        w_reject    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end else if (r_pulse_cnt != c_CNT_MAX) begin
                    w_pulse_cnt_nxt = r_pulse_cnt + 1'b1;
                end
            end
            S_RX: begin
                if (w_rise) begin
                    // A new sync pulse cuts the window short and starts measuring at once.
                    w_trunc         = 1'b1;
                    w_state_nxt     = S_HIGH;
                    w_pulse_cnt_nxt = c_CNT_ONE;
                end else begin
                    w_in_win = 1'b1;
                    if (r_win_cnt == c_WIN_LAST) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_win_cnt_nxt = r_win_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_WAIT_LOW;
            end
        endcase
    end

    logic                  r_rx_valid;
    logic                  r_rx_trig;
    logic                  r_sync_locked;
    logic                  r_sync_err;
    logic [CNT_WIDTH-1:0]  r_pulse_len;
    logic [DATA_WIDTH-1:0] r_irx_out;
    logic [DATA_WIDTH-1:0] r_qrx_out;

    // State/counter registers and registered outputs; IQ is gated to zero outside the window.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_WAIT_LOW;
            r_pulse_cnt   <= '0;
            r_win_cnt     <= '0;
            r_rx_valid    <= 1'b0;
            r_rx_trig     <= 1'b0;
            r_sync_locked <= 1'b0;
            r_sync_err    <= 1'b0;
            r_pulse_len   <= '0;
            r_irx_out     <= '0;
            r_qrx_out     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pulse_cnt <= w_pulse_cnt_nxt;
            r_win_cnt   <= w_win_cnt_nxt;
            r_rx_valid  <= w_in_win;
            r_rx_trig   <= w_in_win && (r_win_cnt == '0);
            r_sync_err  <= w_reject | w_trunc;
            r_irx_out   <= w_in_win ? bus.irx : '0;
            r_qrx_out   <= w_in_win ? bus.qrx : '0;
            if (w_accept) begin
                r_sync_locked <= 1'b1;
            end else if (w_reject || w_trunc) begin
                r_sync_locked <= 1'b0;
            end
            if (w_accept || w_reject) begin
                r_pulse_len <= r_pulse_cnt;
            end
        end
    end

    assign bus.rx_valid    = r_rx_valid;
    assign bus.rx_trig     = r_rx_trig;
    assign bus.sync_locked = r_sync_locked;
    assign bus.sync_err    = r_sync_err;
    assign bus.pulse_len   = r_pulse_len;
    assign bus.irx_out     = r_irx_out;
    assign bus.qrx_out     = r_qrx_out;

`ifdef MRX_NOISE_EST_EN
    localparam logic [CNT_WIDTH-1:0] c_HALF = CNT_WIDTH'(SYNC_SIG_N);

    // Magnitude one bit wider than the sample so that the most negative value is exact.
    function automatic logic [DATA_WIDTH:0] f_abs(input logic [DATA_WIDTH-1:0] v);
        logic [DATA_WIDTH:0] ext;
        ext = {v[DATA_WIDTH-1], v};
        return v[DATA_WIDTH-1] ? (~ext + 1'b1) : ext;
    endfunction

    logic [DATA_WIDTH+1:0] w_mag_sum;
    logic [c_NF_W:0]       w_acc_sum;
    logic [c_NF_W-1:0]     r_acc;
    logic [c_NF_W-1:0]     r_noise_floor;

    assign w_mag_sum = {1'b0, f_abs(bus.irx)} + {1'b0, f_abs(bus.qrx)};
    assign w_acc_sum = {1'b0, r_acc} + (c_NF_W+1)'(w_mag_sum);

    // Accumulate |I|+|Q| while TX is silent (second half of the pulse); publish on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc         <= '0;
            r_noise_floor <= '0;
        end else begin
            if (w_rise) begin
                r_acc <= '0;
            end else if ((r_state == S_HIGH) && (r_pulse_cnt >= c_HALF)) begin
                r_acc <= w_acc_sum[c_NF_W] ? {c_NF_W{1'b1}} : w_acc_sum[c_NF_W-1:0];
            end
            if (w_accept) begin
                r_noise_floor <= r_acc;
            end
        end
    end

    assign bus.noise_floor = r_noise_floor;
`else
    assign bus.noise_floor = {c_NF_W{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_mrx_sync_det.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mrx_sync_det
//  Brief    : Self-checking bench for mrx_sync_det with shortened pulse and
//             window lengths. Table of pulse lengths, random pulses against a
//             length-based acceptance model, and directed corner sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mrx_sync_det;

    localparam int DW   = 16;
    localparam int GW   = 12;
    localparam int CW   = 16;
    localparam int SB   = 1;
    localparam int HALF = 64;
    localparam int TOL  = 4;
    localparam int GL   = 4;
    localparam int WIN  = 300;
    localparam int NOM  = 2 * HALF;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mrx_sync_det_if #(.DATA_WIDTH(DW), .GPIO_REG_WIDTH(GW), .CNT_WIDTH(CW)) bus ();

    mrx_sync_det #(
        .DATA_WIDTH(DW), .GPIO_REG_WIDTH(GW), .SYNC_BIT(SB), .SYNC_SIG_N(HALF),
        .SYNC_TOL(TOL), .GLITCH_LEN(GL), .CNT_WIDTH(CW), .RX_WIN_LEN(WIN)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: counts events and checks IQ pass-through / gating every cycle.
    int n_valid = 0;
    int n_trig  = 0;
    int n_err   = 0;
    logic prev_valid = 1'b0;
    logic [DW-1:0] prev_i = '0;
    logic [DW-1:0] prev_q = '0;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.rx_valid) begin
                n_valid++;
                check("iq_pass", longint'({bus.irx_out, bus.qrx_out}), longint'({prev_i, prev_q}));
            end else begin
                check("iq_gate", longint'({bus.irx_out, bus.qrx_out}), 0);
            end
            if (bus.rx_trig) begin
                n_trig++;
                check("trig_first_valid", longint'({bus.rx_valid, prev_valid}), 2);
            end
            if (bus.sync_err) n_err++;
        end
        prev_valid = bus.rx_valid;
        prev_i     = bus.irx;
        prev_q     = bus.qrx;
    end

    logic rand_iq = 1'b1;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_iq) begin
                bus.irx = DW'($urandom);
                bus.qrx = DW'($urandom);
            end
        end
    endtask

    task automatic pulse(input int len);
        bus.gpio_in[SB] = 1'b1;
        step(len);
        bus.gpio_in[SB] = 1'b0;
    endtask

    // Reference: a pulse is accepted when its length is within TOL of 2*HALF.
    function automatic bit model_accept(input int len);
        int d;
        d = len - NOM;
        if (d < 0) d = -d;
        return d <= TOL;
    endfunction

    task automatic run_pulse(input string tag, input int len, input int gap, input bit exp_acc);
        int v0, t0, e0;
        step(gap);
        v0 = n_valid; t0 = n_trig; e0 = n_err;
        pulse(len);
        step(WIN + 40);
        check({tag, "_len"},    longint'(bus.pulse_len), len);
        check({tag, "_valid"},  n_valid - v0, exp_acc ? WIN : 0);
        check({tag, "_trig"},   n_trig - t0, exp_acc ? 1 : 0);
        check({tag, "_err"},    n_err - e0, exp_acc ? 0 : 1);
        check({tag, "_locked"}, longint'(bus.sync_locked), longint'(exp_acc));
    endtask

    typedef struct {
        int len;
        bit exp_acc;
    } vec_t;

    vec_t tbl[8];

    longint exp_noise;

    initial begin
        int v0, t0, e0, v1;
        tbl[0] = '{NOM,           1'b1};
        tbl[1] = '{NOM - TOL,     1'b1};
        tbl[2] = '{NOM + TOL,     1'b1};
        tbl[3] = '{NOM - TOL - 1, 1'b0};
        tbl[4] = '{NOM + TOL + 1, 1'b0};
        tbl[5] = '{HALF,          1'b0};
        tbl[6] = '{200,           1'b0};
        tbl[7] = '{NOM + 2,       1'b1};

        // Reset with the sync line already high.
        bus.gpio_in = 12'h022;
        bus.irx = '0;
        bus.qrx = '0;
        step(5);
        check("rst_valid",  longint'(bus.rx_valid), 0);
        check("rst_trig",   longint'(bus.rx_trig), 0);
        check("rst_locked", longint'(bus.sync_locked), 0);
        check("rst_err",    longint'(bus.sync_err), 0);
        check("rst_len",    longint'(bus.pulse_len), 0);
        check("rst_noise",  longint'(bus.noise_floor), 0);
        reset = 1'b0;
        step(200);
        bus.gpio_in[SB] = 1'b0;
        step(30);
        check("hi_at_rst_trig", n_trig, 0);
        check("hi_at_rst_err",  n_err, 0);
        check("hi_at_rst_len",  longint'(bus.pulse_len), 0);

        // Table of pulse lengths around the tolerance boundaries.
        for (int k = 0; k < 8; k++) begin
            run_pulse($sformatf("tbl%0d", k), tbl[k].len, 30, tbl[k].exp_acc);
        end

        // 3-cycle glitch while idle: no edge at all.
        v0 = n_valid; t0 = n_trig; e0 = n_err;
        step(20);
        pulse(GL - 1);
        step(40);
        check("glitch_idle_trig", n_trig - t0, 0);
        check("glitch_idle_err",  n_err - e0, 0);
        check("glitch_idle_len",  longint'(bus.pulse_len), NOM + 2);

        // 3-cycle glitch inside the window: window runs to full length.
        v0 = n_valid; e0 = n_err;
        pulse(NOM);
        step(50);
        pulse(GL - 1);
        step(WIN + 20);
        check("glitch_rx_valid", n_valid - v0, WIN);
        check("glitch_rx_err",   n_err - e0, 0);

        // 3-cycle low dropout inside the high phase is bridged.
        step(20);
        bus.gpio_in[SB] = 1'b1;
        step(60);
        bus.gpio_in[SB] = 1'b0;
        step(GL - 1);
        pulse(NOM - 60 - (GL - 1) + 1);
        step(WIN + 40);
        check("dropout_len",    longint'(bus.pulse_len), NOM + 1);
        check("dropout_locked", longint'(bus.sync_locked), 1);

        // New pulse rising 100 cycles into a window: the window sees 99 valid
        // cycles (the rising-edge cycle itself is already suppressed).
        step(20);
        v0 = n_valid; t0 = n_trig; e0 = n_err;
        pulse(NOM);
        step(100);
        pulse(NOM);
        v1 = n_valid;
        check("trunc_valid",  v1 - v0, 99);
        check("trunc_err",    n_err - e0, 1);
        check("trunc_locked", longint'(bus.sync_locked), 0);
        step(WIN + 40);
        check("trunc_win2_valid", n_valid - v1, WIN);
        check("trunc_trig",       n_trig - t0, 2);
        check("trunc_len",        longint'(bus.pulse_len), NOM);
        check("trunc_relock",     longint'(bus.sync_locked), 1);

        // Noise estimate with constant IQ across the pulse.
        rand_iq = 1'b0;
        bus.irx = 16'h8000;
        bus.qrx = 16'd100;
        step(20);
        pulse(NOM);
        step(20);
`ifdef MRX_NOISE_EST_EN
        exp_noise = longint'(NOM - HALF) * (32768 + 100);
`else
        exp_noise = 0;
`endif
        check("noise_floor", longint'(bus.noise_floor), exp_noise);
        rand_iq = 1'b1;
        step(WIN + 20);
        run_pulse("noise_rej", NOM + 20, 20, 1'b0);
        check("noise_hold", longint'(bus.noise_floor), exp_noise);

        // Reset in the middle of a window: closes next cycle without an error.
        step(20);
        e0 = n_err;
        pulse(NOM);
        step(50);
        check("midrst_pre_valid", longint'(bus.rx_valid), 1);
        reset = 1'b1;
        step(1);
        check("midrst_valid",  longint'(bus.rx_valid), 0);
        check("midrst_locked", longint'(bus.sync_locked), 0);
        reset = 1'b0;
        step(20);
        check("midrst_err", n_err - e0, 0);

        // Random pulse lengths around nominal against the acceptance model.
        for (int k = 0; k < 24; k++) begin
            int len, gap;
            len = $urandom_range(NOM + 10, NOM - 10);
            gap = $urandom_range(60, 20);
            run_pulse($sformatf("rnd%0d", k), len, gap, model_accept(len));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
